// File: rtl/cof_seq_ctrl.sv
// Coefficient sequencer: fetches one packed 168-bit ROM word per request and
// streams its four coefficients (c3..c0) to the Horner datapath.
module cof_seq_ctrl #(
  parameter int SEG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SEG_WIDTH-1:0] req_seg,
  input  logic                 req_sin_or_cos,
  input  logic                 req_sel_DorX,
  input  logic                 req_sign_rev,
  input  logic                 flush,
  output logic                 rom_rd,
  output logic [SEG_WIDTH-1:0] rom_addr,
  input  logic [167:0]         rom_data,
  output logic                 cof_valid,
  input  logic                 cof_ready,
  output logic [1:0]           cof_idx,
  output logic                 cof_last,
  output logic [7:0]           cof_exp,
  output logic [39:0]          cof_frac,
  output logic                 cof_sign,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, ISSUE} state_t;

  state_t               state, state_nxt;
  logic [SEG_WIDTH-1:0] seg_q;
  logic                 soc_q, dorx_q, srev_q;
  logic [167:0]         hold_q;
  logic [1:0]           idx_q;
  logic                 accept, beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // req_ready is gated by rst so it reads 0 while reset is held.
  always_comb begin
    state_nxt = state;
    req_ready = (state == IDLE) & ~flush & ~rst;
    accept    = req_valid & req_ready;
    rom_rd    = (state == FETCH);
    rom_addr  = rom_rd ? seg_q : '0;
    cof_valid = (state == ISSUE);
    beat      = cof_valid & cof_ready;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (accept) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = ISSUE;
      ISSUE:   if (beat && idx_q == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q  <= '0;
      soc_q  <= 1'b0;
      dorx_q <= 1'b0;
      srev_q <= 1'b0;
      hold_q <= '0;
      idx_q  <= 2'd0;
    end else begin
      if (accept) begin
        seg_q  <= req_seg;
        soc_q  <= req_sin_or_cos;
        dorx_q <= req_sel_DorX;
        srev_q <= req_sign_rev;
      end
      if (state == LOAD) begin
        hold_q <= rom_data;
        idx_q  <= 2'd3;
      end else if (beat && !flush) begin
        idx_q  <= idx_q - 2'd1;
      end
    end
  end

  // c3/c2 carry 35-bit fractions left-aligned; c0 exponent is always negative.
  always_comb begin
    cof_idx  = 2'd0;
    cof_last = 1'b0;
    cof_exp  = 8'd0;
    cof_frac = 40'd0;
    cof_sign = 1'b0;
    if (state == ISSUE) begin
      cof_idx  = idx_q;
      cof_last = (idx_q == 2'd0);
      case (idx_q)
        2'd3: begin
          cof_exp  = {{3{hold_q[39]}}, hold_q[39:35]};
          cof_frac = {1'b1, hold_q[34:0], 4'b0000};
          cof_sign = soc_q ? srev_q : 1'b1;
        end
        2'd2: begin
          cof_exp  = {{3{hold_q[79]}}, hold_q[79:75]};
          cof_frac = {1'b1, hold_q[74:40], 4'b0000};
          cof_sign = 1'b1;
        end
        2'd1: begin
          cof_exp  = {{3{hold_q[123]}}, hold_q[123:119]};
          cof_frac = {1'b1, hold_q[118:80]};
          cof_sign = soc_q & dorx_q;
        end
        default: begin
          cof_exp  = {3'b111, hold_q[167:163]};
          cof_frac = {1'b1, hold_q[162:124]};
          cof_sign = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cof_seq_ctrl.sv
// Directed table-driven bench for cof_seq_ctrl with stall, flush and reset sequences.
module tb_cof_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [5:0]   req_seg;
  logic         req_sin_or_cos, req_sel_DorX, req_sign_rev;
  logic         flush;
  logic         rom_rd;
  logic [5:0]   rom_addr;
  logic [167:0] rom_data;
  logic         cof_valid, cof_ready;
  logic [1:0]   cof_idx;
  logic         cof_last;
  logic [7:0]   cof_exp;
  logic [39:0]  cof_frac;
  logic         cof_sign;
  logic         busy;

  cof_seq_ctrl #(.SEG_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_seg(req_seg), .req_sin_or_cos(req_sin_or_cos), .req_sel_DorX(req_sel_DorX),
    .req_sign_rev(req_sign_rev), .flush(flush), .rom_rd(rom_rd), .rom_addr(rom_addr),
    .rom_data(rom_data), .cof_valid(cof_valid), .cof_ready(cof_ready), .cof_idx(cof_idx),
    .cof_last(cof_last), .cof_exp(cof_exp), .cof_frac(cof_frac), .cof_sign(cof_sign),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]         seg;
    logic               soc, dorx, srev;
    logic [167:0]       data;
    logic [3:0][7:0]    exp;
    logic [3:0][39:0]   frac;
    logic [3:0]         sign;
  } vec_t;

  vec_t tv [5];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [167:0] mk(input logic [4:0] e3, input logic [34:0] f3,
                                      input logic [4:0] e2, input logic [34:0] f2,
                                      input logic [4:0] e1, input logic [38:0] f1,
                                      input logic [4:0] e0, input logic [38:0] f0);
    return {e0, f0, e1, f1, e2, f2, e3, f3};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input vec_t v, input int i, input string tag);
    chk({tag, " valid"}, cof_valid, 1);
    chk({tag, " idx"},   cof_idx, i);
    chk({tag, " last"},  cof_last, (i == 0));
    chk({tag, " exp"},   cof_exp, v.exp[i]);
    chk({tag, " frac"},  cof_frac, v.frac[i]);
    chk({tag, " sign"},  cof_sign, v.sign[i]);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " cof_valid"}, cof_valid, 0);
    chk({tag, " busy"},      busy, 0);
    chk({tag, " rom_rd"},    rom_rd, 0);
    chk({tag, " cof_idx"},   cof_idx, 0);
    chk({tag, " cof_exp"},   cof_exp, 0);
    chk({tag, " cof_frac"},  cof_frac, 0);
    chk({tag, " cof_sign"},  cof_sign, 0);
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_vec(input int k, input int stall, input int flush_idx);
    vec_t  v;
    string tag;
    v = tv[k];
    req_valid = 1'b1; req_seg = v.seg;
    req_sin_or_cos = v.soc; req_sel_DorX = v.dorx; req_sign_rev = v.srev;
    cof_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d req_ready", k), req_ready, 1);
    step();
    req_valid = 1'b0; req_seg = ~v.seg;
    req_sin_or_cos = ~v.soc; req_sel_DorX = ~v.dorx; req_sign_rev = ~v.srev;
    @(negedge clk);
    chk($sformatf("v%0d rom_rd", k), rom_rd, 1);
    chk($sformatf("v%0d rom_addr", k), rom_addr, v.seg);
    chk($sformatf("v%0d busy", k), busy, 1);
    chk($sformatf("v%0d req_ready busy", k), req_ready, 0);
    step();
    rom_data = v.data;
    @(negedge clk);
    chk($sformatf("v%0d rom_rd load", k), rom_rd, 0);
    chk($sformatf("v%0d early valid", k), cof_valid, 0);
    step();
    rom_data = ~v.data;
    for (int b = 0; b < 4; b++) begin
      int i;
      i = 3 - b;
      tag = $sformatf("v%0d c%0d", k, i);
      if (b == 1 && stall > 0) begin
        cof_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk_beat(v, i, {tag, " stall"});
          step();
        end
        cof_ready = 1'b1;
      end
      if (i == flush_idx) begin
        flush = 1'b1;
        @(negedge clk);
        chk_beat(v, i, {tag, " flushbeat"});
        step();
        flush = 1'b0;
        @(negedge clk);
        chk_quiet({tag, " flushed"});
        chk({tag, " flushed req_ready"}, req_ready, 1);
        step();
        @(negedge clk);
        chk({tag, " no c0"}, cof_valid, 0);
        step();
        return;
      end
      @(negedge clk);
      chk_beat(v, i, tag);
      step();
    end
    @(negedge clk);
    chk_quiet($sformatf("v%0d done", k));
    chk($sformatf("v%0d done req_ready", k), req_ready, 1);
    step();
  endtask

  initial begin
    tv[0] = '{seg: 6'd5, soc: 1'b1, dorx: 1'b1, srev: 1'b1,
              data: mk(5'b10010, 35'h1, 5'b00001, 35'h7FFFFFFFF,
                       5'b01111, 39'h0, 5'b00011, 39'h1234567890),
              exp:  {8'hF2, 8'h01, 8'h0F, 8'hE3},
              frac: {40'h8000000010, 40'hFFFFFFFFF0, 40'h8000000000, 40'h9234567890},
              sign: 4'b1110};
    tv[1] = '{seg: 6'd5, soc: 1'b0, dorx: 1'b1, srev: 1'b1,
              data: mk(5'b01010, 35'h400000000, 5'b11111, 35'h0,
                       5'b10000, 39'h7FFFFFFFFF, 5'b00000, 39'h0),
              exp:  {8'h0A, 8'hFF, 8'hF0, 8'hE0},
              frac: {40'hC000000000, 40'h8000000000, 40'hFFFFFFFFFF, 40'h8000000000},
              sign: 4'b1100};
    tv[2] = '{seg: 6'h3F, soc: 1'b1, dorx: 1'b0, srev: 1'b0,
              data: mk(5'b11111, 35'h2AAAAAAAA, 5'b01111, 35'h123456789,
                       5'b00000, 39'h5555555555, 5'b11111, 39'h1),
              exp:  {8'hFF, 8'h0F, 8'h00, 8'hFF},
              frac: {40'hAAAAAAAAA0, 40'h9234567890, 40'hD555555555, 40'h8000000001},
              sign: 4'b0100};
    tv[3] = tv[2];
    tv[3].seg = 6'd0; tv[3].soc = 1'b0; tv[3].sign = 4'b1100;
    tv[4] = tv[0];
    tv[4].seg = 6'h2A; tv[4].dorx = 1'b0; tv[4].sign = 4'b1100;

    rst = 1'b1; req_valid = 1'b0; req_seg = '0; req_sin_or_cos = 1'b0;
    req_sel_DorX = 1'b0; req_sign_rev = 1'b0; flush = 1'b0; cof_ready = 1'b1;
    rom_data = '1;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset req_ready", req_ready, 0);
    chk("reset rom_addr", rom_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset req_ready", req_ready, 1);
    flush = 1'b1;
    #1;
    chk("idle flush req_ready", req_ready, 0);
    flush = 1'b0;
    step();

    for (int k = 0; k < 5; k++) run_vec(k, 0, -1);
    run_vec(0, 5, -1);
    run_vec(1, 0, 1);
    run_vec(2, 0, -1);

    // reset asserted in the middle of LOAD
    req_valid = 1'b1; req_seg = tv[0].seg;
    req_sin_or_cos = 1'b1; req_sel_DorX = 1'b1; req_sign_rev = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    rom_data = tv[0].data;
    #2;
    rst = 1'b1;
    #1;
    chk_quiet("rst-in-load");
    chk("rst-in-load req_ready", req_ready, 0);
    chk("rst-in-load rom_addr", rom_addr, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst release req_ready", req_ready, 1);
    chk("rst release busy", busy, 0);
    step();
    @(negedge clk);
    chk("rst release idle cof_valid", cof_valid, 0);
    step();
    run_vec(3, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
